muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle RV32M execution unit and sequencer in the EX stage, beside the single-cycle ALU.
//  Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU op from ID/EX.
//  Stalls the pipeline while iterating, then presents the result for one cycle.
//  Shift-add multiply and restoring divide, 1 bit per cycle, with signed fix-up.
// PARAMETERS
//  XLEN   32   operand/result width; iteration count = XLEN
// PORTS
//  clk       in   1     clock, rising edge
//  rst       in   1     synchronous, active-high reset
//  StartE    in   1     valid M-ext op in EX this cycle (opcode 0110011, funct7 0000001)
//  FlushE    in   1     kill EX stage (branch/jump redirect)
//  Funct3E   in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  SrcAE     in   XLEN  rs1 operand (forwarded)
//  SrcBE     in   XLEN  rs2 operand (forwarded)
//  StallMD   out  1     freeze IF/ID/EX registers, combinational
//  DoneE     out  1     ResultE valid; single-cycle pulse
//  ResultE   out  XLEN  rd write data
// BEHAVIOUR
//  - Reset: state=IDLE, counter=0, StallMD=0, DoneE=0, ResultE=0; internal regs cleared.
//  - States: IDLE, MUL, DIV, FIX, DONE.
//  - IDLE: StartE&!FlushE latches Funct3E and operands.
//    MUL ops -> MUL; DIV/REM -> DIV; fast-path cases -> DONE.
//  - Operand prep: signed ops (MUL*,DIV,REM) take |SrcA|,|SrcB| per signedness.
//    MULH: both signed. MULHSU: A signed, B unsigned. MULHU/DIVU/REMU: no abs.
//    Record the result sign: product = sA^sB; quotient = sA^sB; remainder = sA.
//  - MUL: 2*XLEN accumulator; each cycle add multiplicand<<i if multiplier bit i set.
//    Runs XLEN cycles (counter 0..XLEN-1), then FIX.
//  - DIV: restoring divide; each cycle shift remainder left, subtract divisor if no borrow,
//    set quotient bit. Runs XLEN cycles, then FIX.
//  - FIX: negate the 64-bit product, quotient or remainder if its sign flag is set.
//    Select the result: MUL low half, MULH/MULHSU/MULHU high half, DIV/DIVU quotient,
//    REM/REMU remainder. Register ResultE; next state DONE.
//  - DONE: DoneE=1 for exactly one cycle, StallMD=0 so the pipeline advances; next state IDLE.
//  - Latency: start in cycle T -> DoneE=1 in cycle T+XLEN+2.
//  - Fast paths (IDLE->DONE, DoneE in T+1):
//    divisor==0: DIV/DIVU -> all ones; REM/REMU -> SrcAE.
//    DIV with SrcA=0x80000000, SrcB=-1: result 0x80000000. REM in the same case: result 0.
//  - StallMD = (state in MUL,DIV,FIX) | (state==IDLE & StartE & !FlushE & !fastpath).
//  - ResultE holds its last value until the next FIX/fast-path update.
//  - StartE is ignored in any state other than IDLE; the pipeline is stalled, so it is a repeat.
//  - FlushE in MUL/DIV/FIX: next state IDLE, no DoneE, ResultE unchanged.
//    FlushE in DONE: DoneE still pulses; the pipeline ignores it because EX is killed.
//  - FlushE & StartE in the same cycle in IDLE: flush wins; nothing starts, StallMD=0.
//  - rst mid-operation: reset values on the next edge; the operation is lost.
//  - Arithmetic is modulo 2^XLEN (2^(2*XLEN) for products); no exceptions are raised.
// TESTING
//  1. MUL 7 x 0xFFFFFFFD -> ResultE=0xFFFFFFEB, DoneE at T+34, StallMD high T..T+33.
//  2. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//     MULH same operands -> 0x00000000. MULHSU -> 0xFFFFFFFF.
//  3. DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
//  4. DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100, both with DoneE at T+1.
//     DIV 0x80000000/-1 -> 0x80000000, DoneE at T+1, StallMD=0 throughout.
//  5. Start DIV, FlushE at T+10 -> IDLE at T+11, no DoneE, StallMD=0.
//     A new MUL at T+12 completes normally.
//  6. rst asserted at T+5 of a MUL -> all outputs 0 next cycle.
//     StartE+FlushE together in IDLE -> no start.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M unit: shift-add multiply and restoring divide, one bit per cycle,
// with sign fix-up, divide fast paths and a combinational pipeline stall.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StartE,
    input  logic            FlushE,
    input  logic [2:0]      Funct3E,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    output logic            StallMD,
    output logic            DoneE,
    output logic [XLEN-1:0] ResultE
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [2:0]          r_f3;
    logic                r_neg;
    logic [2*XLEN-1:0]   r_acc;
    logic [2*XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]     r_mplier;
    logic [XLEN-1:0]     r_quo;
    logic [XLEN-1:0]     r_rem;
    logic [XLEN-1:0]     r_dvsr;
    logic                r_done;
    logic [XLEN-1:0]     r_result;

    logic                w_go;
    logic                w_sgn_a;
    logic                w_sgn_b;
    logic                w_neg_a;
    logic                w_neg_b;
    logic                w_neg_res;
    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;
    logic                w_fast_dz;
    logic                w_fast_ovf;
    logic                w_fast;
    logic [XLEN-1:0]     w_fast_res;
    logic [XLEN:0]       w_rem_sh;
    logic [XLEN:0]       w_diff;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo_fix;
    logic [XLEN-1:0]     w_rem_fix;
    logic [XLEN-1:0]     w_fix_res;

    assign w_go    = StartE & ~FlushE;
    // MULHU, DIVU and REMU treat both operands as unsigned; MULHSU only rs1 as signed
    assign w_sgn_a = (Funct3E != 3'b011) && (Funct3E != 3'b101) && (Funct3E != 3'b111);
    assign w_sgn_b = w_sgn_a && (Funct3E != 3'b010);
    assign w_neg_a = w_sgn_a & SrcAE[XLEN-1];
    assign w_neg_b = w_sgn_b & SrcBE[XLEN-1];
    assign w_abs_a = w_neg_a ? -SrcAE : SrcAE;
    assign w_abs_b = w_neg_b ? -SrcBE : SrcBE;
    // Remainder takes the dividend's sign; product and quotient the XOR of both
    assign w_neg_res = (Funct3E[2] & Funct3E[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);

    assign w_fast_dz  = Funct3E[2] && (SrcBE == '0);
    assign w_fast_ovf = Funct3E[2] && !Funct3E[0] &&
                        (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (SrcBE == '1);
    assign w_fast     = w_fast_dz | w_fast_ovf;

    always_comb begin
        w_fast_res = '0;
        if (w_fast_dz)
            w_fast_res = Funct3E[1] ? SrcAE : '1;
        else if (w_fast_ovf)
            w_fast_res = Funct3E[1] ? '0 : SrcAE;
    end

    assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvsr};

    assign w_prod    = r_neg ? -r_acc : r_acc;
    assign w_quo_fix = r_neg ? -r_quo : r_quo;
    assign w_rem_fix = r_neg ? -r_rem : r_rem;

    always_comb begin
        case (r_f3)
            3'b000:          w_fix_res = w_prod[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:          w_fix_res = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:  w_fix_res = w_quo_fix;
            default:         w_fix_res = w_rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_f3     <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvsr   <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_f3  <= Funct3E;
                        r_neg <= w_neg_res;
                        r_cnt <= '0;
                        if (w_fast) begin
                            r_result <= w_fast_res;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else if (Funct3E[2]) begin
                            r_quo   <= w_abs_a;
                            r_rem   <= '0;
                            r_dvsr  <= w_abs_b;
                            r_state <= S_DIV;
                        end else begin
                            r_acc    <= '0;
                            r_mcand  <= {{XLEN{1'b0}}, w_abs_a};
                            r_mplier <= w_abs_b;
                            r_state  <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    if (FlushE) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (r_mplier[0])
                            r_acc <= r_acc + r_mcand;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == CW'(XLEN-1))
                            r_state <= S_FIX;
                    end
                end
                S_DIV: begin
                    if (FlushE) begin
                        r_state <= S_IDLE;
                    end else begin
                        // Restore on borrow: keep the shifted remainder, quotient bit 0
                        r_quo <= {r_quo[XLEN-2:0], ~w_diff[XLEN]};
                        r_rem <= w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(XLEN-1))
                            r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (FlushE) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_result <= w_fix_res;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign StallMD = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX) ||
                     ((r_state == S_IDLE) && w_go && !w_fast);
    assign DoneE   = r_done;
    assign ResultE = r_result;
endmodule
